// File: rtl/bus_pkg.sv
// Shared definitions for the register-bank bus slave.
// Provides the responder FSM state encoding, the fixed offsets of the
// read-only ID and transaction-count words, and the widths of the two
// request address fields (slave ID in the upper byte, word offset below).
package bus_pkg;

  localparam int SLV_ID_W = 8;
  localparam int OFFS_W   = 8;

  localparam logic [OFFS_W-1:0] ID_OFFSET  = 8'd0;
  localparam logic [OFFS_W-1:0] CNT_OFFSET = 8'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/bus_regbank_mem.sv
// Register array behind the bus slave.
// Ports:
//   clk, reset     - bus clock, asynchronous active-high reset
//   slave_address  - static slave ID, shown at the ID offset
//   wr_en, wr_idx, wr_data - single write port, committed on the rising edge
//   cnt_inc        - bump the completed-transaction counter this edge
//   rd_idx, rd_data - combinational read port with ID/count overlay
module bus_regbank_mem
  import bus_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SLV_ID_W-1:0]   slave_address,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  cnt_inc,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [31:0]           txn_count_q, txn_count_d;

  // Next-state for the bank: the two read-only words are never written
  // even if a write slips through, and the count simply wraps.
  always_comb begin
    regs_d = regs_q;
    if (wr_en && (wr_idx > IDX_W'(CNT_OFFSET))) begin
      regs_d[wr_idx] = wr_data;
    end
    txn_count_d = cnt_inc ? (txn_count_q + 32'd1) : txn_count_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      txn_count_q <= '0;
    end else begin
      regs_q      <= regs_d;
      txn_count_q <= txn_count_d;
    end
  end

  // Read port: offsets 0 and 1 are overlaid with the ID and the count.
  always_comb begin
    rd_data = regs_q[rd_idx];
    if (rd_idx == IDX_W'(ID_OFFSET)) begin
      rd_data = DATA_WIDTH'(slave_address);
    end else if (rd_idx == IDX_W'(CNT_OFFSET)) begin
      rd_data = DATA_WIDTH'(txn_count_q);
    end
  end

endmodule

// File: rtl/bus_regbank_slave.sv
// Responder end of the shared master/slave bus, serving single-word
// reads/writes to a small register bank with programmable wait states.
// Ports:
//   clk, reset     - bus clock, asynchronous active-high reset
//   slave_address  - static ID matched against addr[15:8]
//   req, we, addr, wdata - master request (held until ack)
//   rdata, ack, err - registered response, all zero outside the ack cycle
//   busy           - high from the cycle after accept until back in IDLE
module bus_regbank_slave
  import bus_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [SLV_ID_W-1:0]        slave_address,
  input  logic                       req,
  input  logic                       we,
  input  logic [SLV_ID_W+OFFS_W-1:0] addr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       ack,
  output logic                       err,
  output logic                       busy
);

  localparam int         IDX_W     = $clog2(NUM_REGS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t                state_q, state_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic                  we_q, we_d;
  logic [OFFS_W-1:0]     offs_q, offs_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  accept;
  logic                  cur_we;
  logic                  cur_err;
  logic [OFFS_W-1:0]     cur_offs;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  // In IDLE the request fields are still on the bus (needed when there are
  // no wait states); everywhere else only the latched copy is trusted.
  assign accept   = (state_q == ST_IDLE) && req && (addr[OFFS_W +: SLV_ID_W] == slave_address);
  assign cur_we   = (state_q == ST_IDLE) ? we : we_q;
  assign cur_offs = (state_q == ST_IDLE) ? addr[OFFS_W-1:0] : offs_q;
  assign cur_err  = ({1'b0, cur_offs} >= 9'(NUM_REGS)) ||
                    (cur_we && ((cur_offs == ID_OFFSET) || (cur_offs == CNT_OFFSET)));

  // Handshake FSM: accept, count down wait states, respond once, then
  // park in HOLD until the master releases req so it cannot re-trigger.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    we_d       = we_q;
    offs_d     = offs_q;
    wdata_d    = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d    = we;
          offs_d  = addr[OFFS_W-1:0];
          wdata_d = wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            wait_cnt_d = WAIT_LOAD;
            state_d    = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_HOLD;
      ST_HOLD: begin
        if (!req) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response is computed on the edge entering RESP so ack/err/rdata come
  // straight from flops; RESP always exits, so state_d==RESP means entry.
  always_comb begin
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    if (state_d == ST_RESP) begin
      ack_d = 1'b1;
      err_d = cur_err;
      if (!cur_err && !cur_we) begin
        rdata_d = mem_rd_data;
      end
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      we_q       <= 1'b0;
      offs_q     <= '0;
      wdata_q    <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      we_q       <= we_d;
      offs_q     <= offs_d;
      wdata_q    <= wdata_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      rdata_q    <= rdata_d;
    end
  end

  // Writes and the count bump land on the edge that ends the RESP cycle,
  // so a count read in RESP sees the pre-increment value.
  bus_regbank_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk           (clk),
    .reset         (reset),
    .slave_address (slave_address),
    .wr_en         ((state_q == ST_RESP) && we_q && !err_q),
    .wr_idx        (offs_q[IDX_W-1:0]),
    .wr_data       (wdata_q),
    .cnt_inc       ((state_q == ST_RESP) && !err_q),
    .rd_idx        (cur_offs[IDX_W-1:0]),
    .rd_data       (mem_rd_data)
  );

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_bus_regbank_slave.sv
// Directed bench for two bus_regbank_slave instances (IDs A5 and B2)
// sharing one bus with OR-combined responses.
module tb_bus_regbank_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata_a, rdata_b;
  logic        ack_a, ack_b, err_a, err_b, busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  // Transaction results written by bus_txn and inspected by the tests.
  logic        t_seen;
  logic        t_err;
  logic [31:0] t_rdata;
  int          t_lat;
  int          t_acks_a;
  int          t_acks_b;
  logic        t_busy_a_any;
  logic        t_busy_at_release;

  always #5 clk = ~clk;

  bus_regbank_slave #(.DATA_WIDTH(32), .NUM_REGS(16), .WAIT_CYCLES(2)) u_slave_a (
    .clk           (clk),
    .reset         (reset),
    .slave_address (8'hA5),
    .req           (req),
    .we            (we),
    .addr          (addr),
    .wdata         (wdata),
    .rdata         (rdata_a),
    .ack           (ack_a),
    .err           (err_a),
    .busy          (busy_a)
  );

  bus_regbank_slave #(.DATA_WIDTH(32), .NUM_REGS(16), .WAIT_CYCLES(2)) u_slave_b (
    .clk           (clk),
    .reset         (reset),
    .slave_address (8'hB2),
    .req           (req),
    .we            (we),
    .addr          (addr),
    .wdata         (wdata),
    .rdata         (rdata_b),
    .ack           (ack_b),
    .err           (err_b),
    .busy          (busy_b)
  );

  // Master-side transaction: raise req 1 ns after an edge, wait up to 20
  // edges for an ack on the OR-combined bus, optionally keep req high for
  // extra cycles, then drop it and watch two more cycles for stray acks.
  // Latency counts edges from the accept edge (edge 1).
  task automatic bus_txn(input logic w, input logic [15:0] a, input logic [31:0] d,
                         input int hold_extra);
    req = 1'b1; we = w; addr = a; wdata = d;
    t_seen = 1'b0; t_err = 1'b0; t_rdata = '0; t_lat = 0;
    t_acks_a = 0; t_acks_b = 0; t_busy_a_any = 1'b0; t_busy_at_release = 1'b0;
    for (int cyc = 1; cyc <= 20 && !t_seen; cyc++) begin
      @(posedge clk); #1;
      if (busy_a) t_busy_a_any = 1'b1;
      if (ack_a) t_acks_a++;
      if (ack_b) t_acks_b++;
      if (ack_a || ack_b) begin
        t_seen  = 1'b1;
        t_lat   = cyc;
        t_err   = err_a | err_b;
        t_rdata = rdata_a | rdata_b;
      end
    end
    for (int k = 0; k < hold_extra; k++) begin
      @(posedge clk); #1;
      if (busy_a) t_busy_a_any = 1'b1;
      if (ack_a) t_acks_a++;
      if (ack_b) t_acks_b++;
    end
    t_busy_at_release = busy_a;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      if (ack_a) t_acks_a++;
      if (ack_b) t_acks_b++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ack_a, err_a, busy_a, ack_b, err_b, busy_b} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 000000",
               {ack_a, err_a, busy_a, ack_b, err_b, busy_b});
    end
    checks++;
    if ((rdata_a | rdata_b) !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_rdata: got %h expected 00000000", rdata_a | rdata_b);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    bus_txn(1'b1, 16'hA503, 32'hDEADBEEF, 0);
    checks++;
    if (t_lat !== 3) begin
      errors++;
      $display("[TB] FAIL wr_latency: got %0d expected 3", t_lat);
    end
    checks++;
    if (t_err !== 1'b0 || t_acks_a !== 1) begin
      errors++;
      $display("[TB] FAIL wr_resp: got err=%b acks=%0d expected err=0 acks=1", t_err, t_acks_a);
    end
    bus_txn(1'b0, 16'hA503, 32'h0, 0);
    checks++;
    if (t_rdata !== 32'hDEADBEEF || t_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rd_back: got %h err=%b expected deadbeef err=0", t_rdata, t_err);
    end
  endtask

  task automatic test_readonly();
    bus_txn(1'b0, 16'hA500, 32'h0, 0);
    checks++;
    if (t_rdata !== 32'h000000A5 || t_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rd_id: got %h err=%b expected 000000a5 err=0", t_rdata, t_err);
    end
    // Three good transactions so far; this read sees the pre-increment value.
    bus_txn(1'b0, 16'hA501, 32'h0, 0);
    checks++;
    if (t_rdata !== 32'd3) begin
      errors++;
      $display("[TB] FAIL rd_count: got %0d expected 3", t_rdata);
    end
    bus_txn(1'b1, 16'hA501, 32'hFFFF0000, 0);
    checks++;
    if (t_seen !== 1'b1 || t_err !== 1'b1 || t_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL wr_count_err: got ack=%b err=%b rdata=%h expected 1 1 0",
               t_seen, t_err, t_rdata);
    end
    bus_txn(1'b1, 16'hA500, 32'h11111111, 0);
    checks++;
    if (t_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wr_id_err: got err=%b expected 1", t_err);
    end
    // Only the count read counted since the last look; error writes did not.
    bus_txn(1'b0, 16'hA501, 32'h0, 0);
    checks++;
    if (t_rdata !== 32'd4) begin
      errors++;
      $display("[TB] FAIL count_unchanged: got %0d expected 4", t_rdata);
    end
  endtask

  task automatic test_two_slaves();
    bus_txn(1'b1, 16'hB204, 32'h12345678, 0);
    checks++;
    if (t_acks_b !== 1 || t_acks_a !== 0) begin
      errors++;
      $display("[TB] FAIL b2_only: got acks_a=%0d acks_b=%0d expected 0 1", t_acks_a, t_acks_b);
    end
    checks++;
    if (t_busy_a_any !== 1'b0) begin
      errors++;
      $display("[TB] FAIL a5_busy: got %b expected 0", t_busy_a_any);
    end
    bus_txn(1'b0, 16'hA504, 32'h0, 0);
    checks++;
    if (t_rdata !== 32'h0 || t_acks_a !== 1) begin
      errors++;
      $display("[TB] FAIL a5_reg4: got %h acks=%0d expected 00000000 acks=1", t_rdata, t_acks_a);
    end
    bus_txn(1'b0, 16'hB204, 32'h0, 0);
    checks++;
    if (t_rdata !== 32'h12345678) begin
      errors++;
      $display("[TB] FAIL b2_reg4: got %h expected 12345678", t_rdata);
    end
  endtask

  task automatic test_out_of_range();
    bus_txn(1'b0, 16'hA510, 32'h0, 0);
    checks++;
    if (t_seen !== 1'b1 || t_err !== 1'b1 || t_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL oor_read: got ack=%b err=%b rdata=%h expected 1 1 0",
               t_seen, t_err, t_rdata);
    end
    bus_txn(1'b1, 16'hA5FF, 32'hCAFEF00D, 0);
    checks++;
    if (t_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL oor_write: got err=%b expected 1", t_err);
    end
    bus_txn(1'b0, 16'hC000, 32'h0, 0);
    checks++;
    if (t_seen !== 1'b0 || t_acks_a !== 0 || t_acks_b !== 0) begin
      errors++;
      $display("[TB] FAIL no_slave: got acks_a=%0d acks_b=%0d expected 0 0", t_acks_a, t_acks_b);
    end
  endtask

  task automatic test_hold_req();
    bus_txn(1'b1, 16'hA506, 32'h0BADCAFE, 5);
    checks++;
    if (t_acks_a !== 1) begin
      errors++;
      $display("[TB] FAIL hold_acks: got %0d expected 1", t_acks_a);
    end
    checks++;
    if (t_busy_at_release !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_busy: got %b expected 1", t_busy_at_release);
    end
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_idle: got busy=%b expected 0", busy_a);
    end
    bus_txn(1'b0, 16'hA506, 32'h0, 0);
    checks++;
    if (t_lat !== 3 || t_rdata !== 32'h0BADCAFE) begin
      errors++;
      $display("[TB] FAIL hold_next: got lat=%0d rdata=%h expected 3 0badcafe", t_lat, t_rdata);
    end
  endtask

  task automatic test_reset_abort();
    int acks;
    acks = 0;
    req = 1'b1; we = 1'b1; addr = 16'hA505; wdata = 32'h55AA55AA;
    repeat (2) begin
      @(posedge clk); #1;
      if (ack_a) acks++;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_busy: got %b expected 0", busy_a);
    end
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    @(posedge clk); #1;
    if (ack_a) acks++;
    reset = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack_a) acks++;
    end
    checks++;
    if (acks !== 0) begin
      errors++;
      $display("[TB] FAIL abort_ack: got %0d acks expected 0", acks);
    end
    bus_txn(1'b0, 16'hA505, 32'h0, 0);
    checks++;
    if (t_rdata !== 32'h0 || t_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_reg5: got %h err=%b expected 00000000 err=0", t_rdata, t_err);
    end
    bus_txn(1'b0, 16'hA503, 32'h0, 0);
    checks++;
    if (t_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL abort_reg3: got %h expected 00000000", t_rdata);
    end
    // Count restarted at zero; only the two reads above have completed.
    bus_txn(1'b0, 16'hA501, 32'h0, 0);
    checks++;
    if (t_rdata !== 32'd2) begin
      errors++;
      $display("[TB] FAIL abort_count: got %0d expected 2", t_rdata);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_write_read();
    test_readonly();
    test_two_slaves();
    test_out_of_range();
    test_hold_req();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
